exc_ctrl: RTL



---
 rtl/exc_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// Exception controller: latches faulting PC/cause into ELR/ESR, redirects fetch to the handler and back on ERET.
// Latency: an event sampled at edge t updates ELR/ESR/ECNT at t; Redirect is asserted for the cycle t..t+1.
// Backpressure: none; the block never stalls. ExtIRQ is level-sensitive and simply stays pending until accepted.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   InstrValid                  qualifies NotAnInstr / EStatus / ERet / PC
//   NotAnInstr, EStatus, ERet   exception outputs of the main decoder
//   PC                          PC of the instruction being decoded
//   ExtIRQ / IRQAck             level interrupt request / one-cycle accept pulse
//   Redirect / RedirectPC       fetch redirect and target (handler vector or ELR)
//   InHandler, DoubleFault      handler-active flag, sticky halt flag
//   SysRegSel / SysRegData      MRS read port: 00 ELR, 01 ESR, 10 ECNT, 11 status
module exc_ctrl #(
    parameter int              N         = 64,
    parameter logic [N-1:0]    VECTOR    = 64'h0000_0000_0000_00D8,
    parameter logic [3:0]      IRQ_CODE  = 4'b0001,
    parameter logic [3:0]      ERET_CODE = 4'b0011
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         InstrValid,
    input  logic         NotAnInstr,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic [N-1:0] PC,
    input  logic         ExtIRQ,
    output logic         IRQAck,
    output logic         Redirect,
    output logic [N-1:0] RedirectPC,
    output logic         InHandler,
    output logic         DoubleFault,
    input  logic [1:0]   SysRegSel,
    output logic [N-1:0] SysRegData
);

    typedef enum logic [2:0] {
        S_NORMAL  = 3'd0,
        S_TAKE    = 3'd1,
        S_HANDLER = 3'd2,
        S_RETURN  = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_elr;
    logic [3:0]     r_esr;
    logic [15:0]    r_ecnt;
    logic           r_dfault;

    logic           w_nai;
    logic           w_eret;
    logic           w_take;
    logic [3:0]     w_cause;
    logic           w_irq_ack;
    logic           w_set_df;
    logic           w_redirect;
    logic [N-1:0]   w_redirect_pc;
    logic           w_in_handler;
    logic           w_halted;

    assign w_nai  = InstrValid & NotAnInstr;
    assign w_eret = InstrValid & ERet;

    always_comb begin
        w_state_nxt   = r_state;
        w_take        = 1'b0;
        w_cause       = r_esr;
        w_irq_ack     = 1'b0;
        w_set_df      = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        w_in_handler  = 1'b0;
        w_halted      = 1'b0;

        unique case (r_state)
            S_NORMAL: begin
                // Priority NotAnInstr > ERet > ExtIRQ. The interrupt does not
                // need a valid instruction; the interrupted one is re-executed.
                if (w_nai) begin
                    w_take  = 1'b1;
                    w_cause = EStatus;
                end else if (w_eret) begin
                    w_take  = 1'b1;
                    w_cause = ERET_CODE;
                end else if (ExtIRQ) begin
                    w_take    = 1'b1;
                    w_cause   = IRQ_CODE;
                    w_irq_ack = 1'b1;
                end
                if (w_take) begin
                    w_state_nxt = S_TAKE;
                end
            end
            S_TAKE: begin
                w_redirect    = 1'b1;
                w_redirect_pc = VECTOR;
                w_in_handler  = 1'b1;
                w_state_nxt   = S_HANDLER;
            end
            S_HANDLER: begin
                // Interrupts are masked here; a fault inside the handler is fatal.
                w_in_handler = 1'b1;
                if (w_nai) begin
                    w_state_nxt = S_HALT;
                    w_set_df    = 1'b1;
                end else if (w_eret) begin
                    w_state_nxt = S_RETURN;
                end
            end
            S_RETURN: begin
                w_redirect    = 1'b1;
                w_redirect_pc = r_elr;
                w_in_handler  = 1'b1;
                w_state_nxt   = S_NORMAL;
            end
            S_HALT: begin
                w_redirect    = 1'b1;
                w_redirect_pc = VECTOR;
                w_halted      = 1'b1;
            end
            default: begin
                w_state_nxt = S_NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_NORMAL;
            r_elr    <= '0;
            r_esr    <= '0;
            r_ecnt   <= '0;
            r_dfault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_elr <= PC;
                r_esr <= w_cause;
                if (r_ecnt != 16'hFFFF) begin
                    r_ecnt <= r_ecnt + 16'd1;
                end
            end
            if (w_set_df) begin
                r_dfault <= 1'b1;
            end
        end
    end

    // Acceptance is suppressed while reset is held, since nothing is latched then.
    assign IRQAck      = w_irq_ack & ~reset;
    assign Redirect    = w_redirect;
    assign RedirectPC  = w_redirect_pc;
    assign InHandler   = w_in_handler;
    assign DoubleFault = r_dfault;

    always_comb begin
        SysRegData = '0;
        unique case (SysRegSel)
            2'b00:   SysRegData = r_elr;
            2'b01:   SysRegData = {{(N-4){1'b0}}, r_esr};
            2'b10:   SysRegData = {{(N-16){1'b0}}, r_ecnt};
            default: SysRegData = {{(N-3){1'b0}}, r_dfault, w_in_handler, w_halted};
        endcase
    end

endmodule
